debounce2: RTL and testbench

DEBOUNCE2 -- requirements
Module: debounce2

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_ch.sv | 131 +++++++++++++
 rtl/debounce2.sv | 43 ++++
 tb/tb_debounce2.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the two-channel switch debouncer: per-channel FSM
// state encodings and the default stability window.
package debounce_pkg;

  // 10 ms at 100 MHz
  localparam int unsigned STABLE_CNT_DEFAULT = 1000000;

  localparam logic [1:0] ST_LOW_STABLE  = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH   = 2'd1;
  localparam logic [1:0] ST_HIGH_STABLE = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW    = 2'd3;

endpackage : debounce_pkg

// File: rtl/debounce_ch.sv
// Single debounce channel: two-flop synchronizer, 4-state stability FSM with
// its own counter, and optional registered edge pulses.
// Edge pulses exist only when DEBOUNCE2_EDGE_EN is defined; otherwise rise_o
// and fall_o are tied low and no edge flops are built.
//
// state          | meaning
// ST_LOW_STABLE  | accepted level is 0, synchronized input agrees
// ST_WAIT_HIGH   | input went 1, counting stable clocks before accepting 1
// ST_HIGH_STABLE | accepted level is 1, synchronized input agrees
// ST_WAIT_LOW    | input went 0, counting stable clocks before accepting 0
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEFAULT,
  parameter int unsigned CNT_W      = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Bring the asynchronous switch level into the clk domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Next-state logic: a level is accepted only after STABLE_CNT consecutive
  // clocks of agreement; any reversion aborts and clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      ST_LOW_STABLE: begin
        if (s2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = ST_LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH_STABLE;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH_STABLE: begin
        if (!s2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_LOW: begin
        if (s2_q) begin
          state_d = ST_HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW_STABLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW_STABLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counter and accepted level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOW_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

`ifdef DEBOUNCE2_EDGE_EN
  logic rise_q, fall_q;

  // Edge pulses register on the same edge as the level, so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : debounce_ch

// File: rtl/debounce2.sv
// Two independent debounced switch inputs feeding a downstream two-input gate.
// in_raw[0] -> a, in_raw[1] -> b. Edge pulses on rise/fall are built only
// with DEBOUNCE2_EDGE_EN defined; otherwise both are constant 0.
module debounce2
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEFAULT,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_raw,
  output logic       a,
  output logic       b,
  output logic [1:0] rise,
  output logic [1:0] fall
);

  // Reject stability windows the counter cannot hold, or too short to filter.
  if (STABLE_CNT < 2 || 64'(STABLE_CNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cfg
    $error("debounce2: STABLE_CNT out of range for CNT_W");
  end

  logic [1:0] level;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (in_raw[i]),
      .level_o (level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  assign a = level[0];
  assign b = level[1];

endmodule : debounce2

// File: tb/tb_debounce2.sv
module tb_debounce2;

  localparam int SC = 4;
  localparam int CW = 3;

`ifdef DEBOUNCE2_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_raw = 2'b00;
  logic       a, b;
  logic [1:0] rise, fall;

  int n_checks = 0;
  int n_fail   = 0;

  debounce2 #(.STABLE_CNT(SC), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_raw (in_raw),
    .a      (a),
    .b      (b),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, act=running req=finished");
    $fatal(1, "timeout");
  end

  // Behavioural reference: a level is accepted once the synchronized input
  // has disagreed with the accepted level for SC consecutive clocks.
  logic [1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
  int         m_run [2] = '{0, 0};

  task automatic model_step(input logic r, input logic [1:0] in);
    logic [1:0] nout;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      m_run[0] = 0; m_run[1] = 0;
      return;
    end
    nout = m_out;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_out[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == SC) begin
          nout[i]  = ~m_out[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rise = EDGE_EN ? (nout & ~m_out) : 2'b00;
    m_fall = EDGE_EN ? (~nout & m_out) : 2'b00;
    m_out  = nout;
    m_s2   = m_s1;
    m_s1   = in;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%b req=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, step model, sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic [1:0] in, input string name);
    rst    = r;
    in_raw = in;
    @(posedge clk);
    model_step(r, in);
    #1;
    chk({name, "_model"}, {2'b00, b, a, rise, fall}, {2'b00, m_out, m_rise, m_fall});
    chk({name, "_excl"}, {6'b0, rise & fall}, 8'h00);
  endtask

  typedef struct {
    logic       r;
    logic [1:0] in;
    logic [1:0] ab;    // {b,a}
    logic [1:0] rs;
    logic [1:0] fl;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [1:0] ed(input logic [1:0] v);
    return EDGE_EN ? v : 2'b00;
  endfunction

  int hold [2];
  logic [1:0] lvl;

  initial begin
    // Reset with inputs high, then a clean press on channel 0.
    tbl.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 2'b00});
    for (int e = 1; e <= 5; e++) tbl.push_back('{1'b0, 2'b01, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b01, 2'b01, 2'b01, 2'b00});   // edge 6
    tbl.push_back('{1'b0, 2'b01, 2'b01, 2'b00, 2'b00});   // edge 7
    tbl.push_back('{1'b0, 2'b01, 2'b01, 2'b00, 2'b00});
    // Release channel 0.
    for (int e = 1; e <= 5; e++) tbl.push_back('{1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 2'b01});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 2'b00});

    for (int k = 0; k < tbl.size(); k++) begin
      tick(tbl[k].r, tbl[k].in, "tbl");
      chk($sformatf("tbl_vec%0d", k), {2'b00, b, a, rise, fall},
          {2'b00, tbl[k].ab, ed(tbl[k].rs), ed(tbl[k].fl)});
    end

    // Glitch: 3 clocks high on channel 0 must never be accepted.
    for (int k = 0; k < 3; k++) tick(1'b0, 2'b01, "glitch_hi");
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 2'b00, "glitch_lo");
      chk("glitch_a", {6'b0, a, rise[0]}, 8'h00);
    end

    // Bounce on channel 1, then hold: b rises at edge 6 of the final sample.
    tick(1'b0, 2'b10, "bounce"); tick(1'b0, 2'b00, "bounce");
    tick(1'b0, 2'b10, "bounce"); tick(1'b0, 2'b00, "bounce");
    for (int j = 1; j <= 8; j++) begin
      tick(1'b0, 2'b10, "bounce_hold");
      chk($sformatf("bounce_e%0d", j), {6'b0, b, rise[1]},
          {6'b0, (j >= 6), (j == 6) & EDGE_EN});
    end

    // Bring a up too, then release both in the same clock.
    for (int j = 1; j <= 8; j++) tick(1'b0, 2'b11, "both_hi");
    chk("both_hi_ab", {6'b0, b, a}, 8'h03);
    for (int j = 1; j <= 7; j++) begin
      tick(1'b0, 2'b00, "release");
      chk($sformatf("release_e%0d", j), {4'b0, b, a, fall},
          {4'b0, (j < 6) ? 2'b11 : 2'b00, (j == 6) ? ed(2'b11) : 2'b00});
    end

    // New press interrupted by reset on edge 4; accepted a full window later.
    for (int j = 1; j <= 3; j++) tick(1'b0, 2'b11, "press_pre");
    tick(1'b1, 2'b11, "press_rst");
    chk("press_rst_out", {4'b0, b, a, rise}, 8'h00);
    for (int j = 1; j <= 7; j++) begin
      tick(1'b0, 2'b11, "press_post");
      chk($sformatf("press_post_e%0d", j), {4'b0, b, a, rise},
          {4'b0, (j >= 6) ? 2'b11 : 2'b00, (j == 6) ? ed(2'b11) : 2'b00});
    end

    // Random bursts of varying hold length, with occasional resets.
    hold[0] = 0; hold[1] = 0; lvl = 2'b11;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 8);
        end
        hold[i]--;
      end
      tick(($urandom_range(0, 299) == 0), lvl, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debounce2
